// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage
//
// Decode stage for the accumulator CPU. It takes the instruction byte stream
// from fetch, turns each opcode into a one-hot control word and collects the
// little-endian address operand for memory and jump opcodes. It then hands
// exactly one registered packet per instruction to the control unit.
//
// Ports
//   clk          in   1        clock, all state on rising edge
//   rst_n        in   1        asynchronous active-low reset
//   flush        in   1        discard partial/pending instruction (taken jump)
//   in_valid     in   1        fetch byte valid
//   in_ready     out  1        stage can accept a byte this cycle
//   in_byte      in   OPW      opcode or operand byte
//   out_valid    out  1        decoded packet valid
//   out_ready    in   1        control unit accepts packet
//   out_decoded  out  NUM_OPS  one-hot instruction (bit0 NOP ... bit15 NOT)
//   out_operand  out  ADDRW    assembled operand, 0 for operand-less opcodes
//   out_illegal  out  1        opcode had bits set above OP_BITS, issued as NOP

module instruction_decode_stage #(
    parameter int OPW     = 8,
    parameter int OP_BITS = 4,
    parameter int ADDRW   = 16,
    parameter int NUM_OPS = 2 ** OP_BITS,
    parameter logic [NUM_OPS-1:0] OPERAND_MASK = 16'h00E6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     in_byte,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OPS-1:0] out_decoded,
    output logic [ADDRW-1:0]   out_operand,
    output logic               out_illegal
);

    localparam int NOPB = ADDRW / OPW;
    localparam int CNTW = $clog2(NOPB) + 1;
    localparam logic [NUM_OPS-1:0] NOP_ONEHOT = {{(NUM_OPS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_OPC = 2'd0,
        S_OPR = 2'd1,
        S_ISS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [NUM_OPS-1:0]  decoded_q, decoded_d;
    logic [ADDRW-1:0]    operand_q, operand_d;
    logic                illegal_q, illegal_d;

    logic                in_accept;
    logic                opc_legal;
    logic [OP_BITS-1:0]  opc_idx;

    assign opc_idx   = in_byte[OP_BITS-1:0];
    assign opc_legal = (in_byte[OPW-1:OP_BITS] == '0);

    // The issue cycle never accepts a byte, and flush blocks acceptance so a
    // byte presented alongside a flush is simply dropped.
    assign in_ready  = (state_q != S_ISS) && !flush;
    assign in_accept = in_valid && in_ready;

    assign out_valid   = (state_q == S_ISS);
    assign out_decoded = decoded_q;
    assign out_operand = operand_q;
    assign out_illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        decoded_d = decoded_q;
        operand_d = operand_q;
        illegal_d = illegal_q;

        case (state_q)
            S_OPC: begin
                if (in_accept) begin
                    operand_d = '0;
                    count_d   = '0;
                    illegal_d = !opc_legal;
                    decoded_d = opc_legal ? (NOP_ONEHOT << opc_idx) : NOP_ONEHOT;
                    // Illegal opcodes are issued as NOP, so they never take an operand.
                    if (opc_legal && OPERAND_MASK[opc_idx]) begin
                        state_d = S_OPR;
                    end else begin
                        state_d = S_ISS;
                    end
                end
            end
            S_OPR: begin
                if (in_accept) begin
                    // Little-endian: byte slot selected by how many bytes arrived so far.
                    for (int b = 0; b < NOPB; b++) begin
                        if (count_q == CNTW'(b)) begin
                            operand_d[b*OPW +: OPW] = in_byte;
                        end
                    end
                    count_d = count_q + CNTW'(1);
                    if (count_q == CNTW'(NOPB - 1)) begin
                        state_d = S_ISS;
                    end
                end
            end
            S_ISS: begin
                if (out_ready) begin
                    state_d = S_OPC;
                end
            end
            default: begin
                state_d = S_OPC;
            end
        endcase

        // Flush wins over any handshake in the same cycle.
        if (flush) begin
            state_d = S_OPC;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OPC;
            count_q   <= '0;
            decoded_q <= NOP_ONEHOT;
            operand_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            decoded_q <= decoded_d;
            operand_q <= operand_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage
//
// Self-checking bench for instruction_decode_stage: a table of directed
// vectors, hand-written multi-cycle sequences (backpressure, flush, reset in
// the middle of an instruction) and a randomized run. A byte-queue reference
// model tracks the instruction being assembled and the packet waiting to issue.

module tb_instruction_decode_stage;

    localparam int OPW     = 8;
    localparam int ADDRW   = 16;
    localparam int NUM_OPS = 16;
    localparam int NOPB    = 2;
    localparam logic [15:0] MASK = 16'h00E6;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [OPW-1:0]     in_byte;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OPS-1:0] out_decoded;
    logic [ADDRW-1:0]   out_operand;
    logic               out_illegal;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the instruction in progress, plus the packet
    // that has been completed and is waiting for the control unit.
    logic [7:0]  m_q[$];
    bit          m_pend;
    logic [15:0] m_dec;
    logic [15:0] m_opr;
    bit          m_ill;

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          r;
        bit          e_valid;
        bit          e_ready;
        logic [15:0] e_dec;
        logic [15:0] e_opr;
        bit          e_ill;
    } vec_t;

    vec_t tbl[10];

    instruction_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_decoded (out_decoded),
        .out_operand (out_operand),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_pend = 1'b0;
        m_dec  = 16'h0001;
        m_opr  = 16'h0000;
        m_ill  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit legal;
        int need;
        logic [7:0] opc;
        if (flush) begin
            m_q.delete();
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 1'b0;
        end else if (in_valid) begin
            m_q.push_back(in_byte);
            opc   = m_q[0];
            legal = (opc[7:4] == 4'h0);
            need  = (legal && MASK[opc[3:0]]) ? NOPB : 0;
            if (m_q.size() == 1 + need) begin
                m_dec = legal ? (16'h0001 << opc[3:0]) : 16'h0001;
                m_ill = !legal;
                m_opr = 16'h0000;
                for (int i = 0; i < need; i++) begin
                    m_opr = m_opr | (16'(m_q[i+1]) << (8 * i));
                end
                m_pend = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("model out_valid", {31'b0, out_valid}, {31'b0, m_pend});
        checkOutput("model in_ready", {31'b0, in_ready}, {31'b0, (!m_pend && !flush)});
        if (m_pend) begin
            checkOutput("model out_decoded", {16'b0, out_decoded}, {16'b0, m_dec});
            checkOutput("model out_operand", {16'b0, out_operand}, {16'b0, m_opr});
            checkOutput("model out_illegal", {31'b0, out_illegal}, {31'b0, m_ill});
        end
    endtask

    // Drive one cycle of inputs and check outputs at the falling edge.
    task automatic applyStimulus(input bit f, input bit v, input logic [7:0] b, input bit r);
        flush     = f;
        in_valid  = v;
        in_byte   = b;
        out_ready = r;
        @(negedge clk);
        checkModel();
    endtask

    task automatic finishCycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPacket(input string name, input bit ev, input bit er,
                               input logic [15:0] ed, input logic [15:0] eo, input bit ei);
        checkOutput({name, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
        checkOutput({name, " in_ready"}, {31'b0, in_ready}, {31'b0, er});
        if (ev) begin
            checkOutput({name, " out_decoded"}, {16'b0, out_decoded}, {16'b0, ed});
            checkOutput({name, " out_operand"}, {16'b0, out_operand}, {16'b0, eo});
            checkOutput({name, " out_illegal"}, {31'b0, out_illegal}, {31'b0, ei});
        end
    endtask

    initial begin
        // ADD, then LDAC 0x1234, then illegal 0xA5 followed by CLAC.
        tbl[0] = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h1234, 1'b0};
        tbl[6] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[7] = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1};
        tbl[8] = '{1'b1, 8'h0B, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("reset out_decoded", {16'b0, out_decoded}, 32'h0001);
        checkOutput("reset out_operand", {16'b0, out_operand}, 32'h0);
        checkOutput("reset out_illegal", {31'b0, out_illegal}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, tbl[i].v, tbl[i].b, tbl[i].r);
            checkPacket($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ready,
                        tbl[i].e_dec, tbl[i].e_opr, tbl[i].e_ill);
            finishCycle();
        end

        $display("[TB] backpressure sequence");
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b1);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'hEF, 1'b1);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'hBE, 1'b1);
        checkPacket("bp last byte", 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
        finishCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h08, 1'b0);
            checkPacket($sformatf("bp hold%0d", i), 1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0);
            finishCycle();
        end
        applyStimulus(1'b0, 1'b1, 8'h08, 1'b1);
        checkPacket("bp release", 1'b1, 1'b0, 16'h0020, 16'hBEEF, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'h08, 1'b1);
        checkPacket("bp after", 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkPacket("bp next pkt", 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0);
        finishCycle();

        $display("[TB] flush sequence");
        applyStimulus(1'b0, 1'b1, 8'h06, 1'b1);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'hEF, 1'b1);
        finishCycle();
        applyStimulus(1'b1, 1'b1, 8'hBE, 1'b1);
        checkOutput("flush in_ready", {31'b0, in_ready}, 32'h0);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'h0B, 1'b1);
        checkPacket("flush dropped", 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkPacket("flush clac", 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkPacket("flush idle", 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
        finishCycle();

        $display("[TB] reset in the middle of an operand");
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b1);
        finishCycle();
        applyStimulus(1'b0, 1'b1, 8'h34, 1'b1);
        finishCycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("midreset in_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("midreset out_decoded", {16'b0, out_decoded}, 32'h0001);
        checkOutput("midreset out_operand", {16'b0, out_operand}, 32'h0);
        checkOutput("midreset out_illegal", {31'b0, out_illegal}, 32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 8'h0B, 1'b1);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkPacket("midreset clac", 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0);
        finishCycle();

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            bit          f, v, r;
            logic [7:0]  b;
            f = ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 8) begin
                b = 8'($urandom_range(0, 15));
            end else begin
                b = 8'($urandom_range(16, 255));
            end
            applyStimulus(f, v, b, r);
            finishCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
